// File: rtl/mul_pkg.sv
// Shared definitions for the pipelined EXE-stage multiplier: op encoding and
// the widest stage payload layout.
package mul_pkg;

  localparam int MUL_OP_W   = 3;
  localparam int MUL_OP_LO  = 0;   // MUL.W    : signed low half
  localparam int MUL_OP_HI  = 1;   // MULH.W   : signed high half
  localparam int MUL_OP_HIU = 2;   // MULH.WU  : unsigned high half

  localparam int MUL_MAX_W     = 64;
  localparam int MUL_MAX_TAG_W = 16;

  typedef logic [MUL_OP_W-1:0] mul_op_t;

  // Payload carried by every stage; instances narrow it to their WIDTH/TAG_W.
  typedef struct packed {
    logic [MUL_MAX_W-1:0]     result;
    logic [MUL_MAX_TAG_W-1:0] tag;
  } mul_payload_t;

endpackage

// File: rtl/mul_pipe_if.sv
// Request/response bus of mul_pipe: valid/ready on the issue side and on the
// result side. The slave modport is the multiplier's view.
interface mul_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic                in_valid;
  logic                in_ready;
  mul_pkg::mul_op_t    in_op;
  logic [WIDTH-1:0]    in_src1;
  logic [WIDTH-1:0]    in_src2;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    out_result;
  logic [TAG_W-1:0]    out_tag;

  modport master (
    output in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
    input  in_ready, out_valid, out_result, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_tag
  );
endinterface

// File: rtl/mul_pipe_slice.sv
// One valid/ready register slice: loads when empty or when its content is
// being taken downstream; flush empties it.
module mul_pipe_slice #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  assign in_ready  = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      // NOTE: the payload is reset as well so the result/tag outputs read 0
      // out of reset instead of X.
      data_q  <= '0;
    end else begin
      if (flush)         valid_q <= 1'b0;
      else if (in_ready) valid_q <= in_valid;
      if (in_valid && in_ready) data_q <= in_data;
    end
  end

endmodule

// File: rtl/mul_pipe.sv
// Pipelined MUL.W / MULH.W / MULH.WU unit with valid/ready on both sides.
// Define MUL_FLUSH_EN to add the flush port that drops all in-flight ops.
module mul_pipe
  import mul_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int TAG_W  = 5
) (
  input  logic clk,
  input  logic resetn,
`ifdef MUL_FLUSH_EN
  input  logic flush,
`endif
  mul_pipe_if.slave bus
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [TAG_W-1:0] tag;
  } stage_t;

  logic kill;
`ifdef MUL_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  // ---------------- stage 0 arithmetic ----------------
  logic signed [2*WIDTH-1:0] src1_x, src2_x, product;
  logic        [WIDTH-1:0]   lo, hi_s, hi_u, sel;

  // One signed multiplier serves all ops: the low half is sign-agnostic and
  // the unsigned high half is the signed one plus the two cross terms that
  // the sign bits subtracted.
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    src1_x  = {{WIDTH{bus.in_src1[WIDTH-1]}}, bus.in_src1};
    src2_x  = {{WIDTH{bus.in_src2[WIDTH-1]}}, bus.in_src2};
    product = src1_x * src2_x;
    lo      = product[WIDTH-1:0];
    hi_s    = product[2*WIDTH-1:WIDTH];
    hi_u    = hi_s + (bus.in_src1[WIDTH-1] ? bus.in_src2 : '0)
                   + (bus.in_src2[WIDTH-1] ? bus.in_src1 : '0);
    sel     = '0;
    if (bus.in_op[MUL_OP_LO])  sel = sel | lo;
    if (bus.in_op[MUL_OP_HI])  sel = sel | hi_s;
    if (bus.in_op[MUL_OP_HIU]) sel = sel | hi_u;
  end

  // ---------------- stage chain ----------------
  // ready_s[k] is the ready seen at the output of stage k.
  logic   valid_s [STAGES];
  logic   ready_s [STAGES];
  stage_t data_s  [STAGES];

  logic   valid0_q;
  stage_t data0_q;

  assign ready_s[STAGES-1] = bus.out_ready;
  assign bus.in_ready      = (~valid0_q | ready_s[0]) & ~kill;
  assign valid_s[0]        = valid0_q;
  assign data_s[0]         = data0_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid0_q <= 1'b0;
      data0_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling
      // pre-edge values, independent of process evaluation order.
      if (kill)                         valid0_q <= 1'b0;
      else if (~valid0_q | ready_s[0])  valid0_q <= bus.in_valid;
      if (bus.in_valid && bus.in_ready)
        data0_q <= stage_t'{result: sel, tag: bus.in_tag};
    end
  end

  for (genvar k = 1; k < STAGES; k++) begin : g_slice
    mul_pipe_slice #(.DATA_W($bits(stage_t))) u_slice (
      .clk       (clk),
      .resetn    (resetn),
      .flush     (kill),
      .in_valid  (valid_s[k-1]),
      .in_ready  (ready_s[k-1]),
      .in_data   (data_s[k-1]),
      .out_valid (valid_s[k]),
      .out_ready (ready_s[k]),
      .out_data  (data_s[k])
    );
  end

  assign bus.out_valid  = valid_s[STAGES-1];
  assign bus.out_result = data_s[STAGES-1].result;
  assign bus.out_tag    = data_s[STAGES-1].tag;

endmodule

// File: tb/tb_mul_pipe.sv
// Scoreboard bench for mul_pipe: a 32-bit/2-stage and a 16-bit/3-stage
// instance driven with hand-computed directed vectors.
module tb_mul_pipe;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          acc;
    bit          lat;
  } exp_t;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
`ifdef MUL_FLUSH_EN
  logic flush  = 1'b0;
`endif

  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q32[$];
  exp_t q16[$];

  bit          stall_seen = 1'b0;
  logic [31:0] hold_res   = '0;
  logic [4:0]  hold_tag   = '0;

  mul_pipe_if #(.WIDTH(32), .TAG_W(5)) b32 ();
  mul_pipe_if #(.WIDTH(16), .TAG_W(5)) b16 ();

  mul_pipe #(.WIDTH(32), .STAGES(2), .TAG_W(5)) dut32 (
    .clk    (clk),
    .resetn (resetn),
`ifdef MUL_FLUSH_EN
    .flush  (flush),
`endif
    .bus    (b32)
  );

  mul_pipe #(.WIDTH(16), .STAGES(3), .TAG_W(5)) dut16 (
    .clk    (clk),
    .resetn (resetn),
`ifdef MUL_FLUSH_EN
    .flush  (flush),
`endif
    .bus    (b16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!resetn) begin
      stall_seen <= 1'b0;
    end else if (b32.out_valid) begin
      if (stall_seen) begin
        check("hold_result32", b32.out_result, hold_res);
        check("hold_tag32", b32.out_tag, hold_tag);
      end
      if (b32.out_ready) begin
        stall_seen <= 1'b0;
        if (q32.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_out32: tag %0d result %0h, expected no output", b32.out_tag, b32.out_result);
        end else begin
          check("result32", b32.out_result, q32[0].res);
          check("tag32", b32.out_tag, q32[0].tag);
          if (q32[0].lat) check("latency32", cyc - q32[0].acc, 2);
          void'(q32.pop_front());
        end
      end else begin
        stall_seen <= 1'b1;
        hold_res   <= b32.out_result;
        hold_tag   <= b32.out_tag;
      end
    end else begin
      stall_seen <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (resetn && b16.out_valid && b16.out_ready) begin
      if (q16.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_out16: tag %0d result %0h, expected no output", b16.out_tag, b16.out_result);
      end else begin
        check("result16", b16.out_result, q16[0].res);
        check("tag16", b16.out_tag, q16[0].tag);
        if (q16[0].lat) check("latency16", cyc - q16[0].acc, 3);
        void'(q16.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic issue32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input logic [31:0] exp_res,
                         input bit track, input bit lat);
    int waited = 0;
    b32.in_valid = 1'b1;
    b32.in_op    = op;
    b32.in_src1  = a;
    b32.in_src2  = b;
    b32.in_tag   = tag;
    @(negedge clk);
    while (!b32.in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!b32.in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout32 tag %0d: in_ready stayed 0, expected 1 within 50 cycles", tag);
    end else if (track) begin
      q32.push_back('{exp_res, tag, cyc, lat});
    end
    @(posedge clk);
    #1;
    b32.in_valid = 1'b0;
  endtask

  task automatic issue16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [4:0] tag, input logic [15:0] exp_res);
    int waited = 0;
    b16.in_valid = 1'b1;
    b16.in_op    = op;
    b16.in_src1  = a;
    b16.in_src2  = b;
    b16.in_tag   = tag;
    @(negedge clk);
    while (!b16.in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!b16.in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout16 tag %0d: in_ready stayed 0, expected 1 within 50 cycles", tag);
    end else begin
      q16.push_back('{{16'h0, exp_res}, tag, cyc, 1'b1});
    end
    @(posedge clk);
    #1;
    b16.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q32.size() != 0 || q16.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check("drained", q32.size() + q16.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    b32.in_valid = 1'b0; b32.in_op = '0; b32.in_src1 = '0; b32.in_src2 = '0;
    b32.in_tag = '0; b32.out_ready = 1'b1;
    b16.in_valid = 1'b0; b16.in_op = '0; b16.in_src1 = '0; b16.in_src2 = '0;
    b16.in_tag = '0; b16.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", b32.out_valid, 0);
    check("rst_in_ready", b32.in_ready, 1);
    check("rst_out_result", b32.out_result, 0);
    check("rst_out_tag", b32.out_tag, 0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // All-ones, min-negative, mixed-sign, multi-hot and op==0 vectors.
    issue32(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'h0000_0001, 1, 1);
    issue32(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 1, 1);
    issue32(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE, 1, 1);
    issue32(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h0000_0000, 1, 1);
    issue32(3'b010, 32'h8000_0000, 32'h8000_0000, 5'd5,  32'h4000_0000, 1, 1);
    issue32(3'b100, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 1, 1);
    issue32(3'b001, 32'h0000_0007, 32'hFFFF_FFFD, 5'd10, 32'hFFFF_FFEB, 1, 1);
    issue32(3'b010, 32'h0000_0007, 32'hFFFF_FFFD, 5'd11, 32'hFFFF_FFFF, 1, 1);
    issue32(3'b100, 32'h0000_0007, 32'hFFFF_FFFD, 5'd12, 32'h0000_0006, 1, 1);
    issue32(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'h0000_0001, 1, 1);
    issue32(3'b000, 32'h0000_1234, 32'h0000_5678, 5'd9,  32'h0000_0000, 1, 1);

    issue16(3'b010, 16'h8000, 16'h8000, 5'd1, 16'h4000);
    issue16(3'b001, 16'h8000, 16'h8000, 5'd2, 16'h0000);
    issue16(3'b100, 16'h8000, 16'h8000, 5'd3, 16'h4000);
    issue16(3'b100, 16'hFFFF, 16'hFFFF, 5'd4, 16'hFFFE);
    drain();

    // Back-pressure: consumer stalls for 5 cycles while 4 ops are offered.
    b32.out_ready = 1'b0;
    fork
      begin
        issue32(3'b001, 32'd3, 32'd5, 5'd1, 32'd15, 1, 0);
        issue32(3'b001, 32'd3, 32'd6, 5'd2, 32'd18, 1, 0);
        issue32(3'b001, 32'd3, 32'd7, 5'd3, 32'd21, 1, 0);
        issue32(3'b001, 32'd3, 32'd8, 5'd4, 32'd24, 1, 0);
      end
      begin
        repeat (3) @(negedge clk);
        check("in_ready_full", b32.in_ready, 0);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        b32.out_ready = 1'b1;
      end
    join
    drain();

`ifdef MUL_FLUSH_EN
    // Flush with tags 7 and 8 in flight; neither may come out.
    b32.out_ready = 1'b0;
    issue32(3'b001, 32'd2, 32'd3, 5'd7, 32'd6, 0, 0);
    issue32(3'b001, 32'd2, 32'd4, 5'd8, 32'd8, 0, 0);
    flush = 1'b1;
    @(negedge clk);
    check("in_ready_flush", b32.in_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check("in_ready_post_flush", b32.in_ready, 1);
    check("out_valid_post_flush", b32.out_valid, 0);
    @(posedge clk);
    #1;
    b32.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
`endif

    // Reset with two ops in flight.
    issue32(3'b001, 32'd5, 32'd5, 5'd20, 32'd25, 0, 0);
    issue32(3'b001, 32'd6, 32'd6, 5'd21, 32'd36, 0, 0);
    resetn = 1'b0;
    #1;
    check("out_valid_in_reset", b32.out_valid, 0);
    check("in_ready_in_reset", b32.in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("out_valid_post_reset", b32.out_valid, 0);
    end
    @(posedge clk);
    #1;
    issue32(3'b100, 32'h8000_0000, 32'h8000_0000, 5'd14, 32'h4000_0000, 1, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_pipe.md
# mul_pipe

Parametrised, pipelined integer multiplier for the EXE stage. It computes the LoongArch MUL.W, MULH.W and MULH.WU results over a configurable operand width and pipeline depth. It uses valid/ready handshakes on both sides, so the core can overlap multiplies with other work, stall on back-pressure, and optionally flush in-flight operations.

## Interface
Parameters:
- WIDTH, 32, operand and result width in bits (8..64).
- STAGES, 2, pipeline depth, i.e. accept-to-output latency in cycles (1..4).
- TAG_W, 5, width of the sideband tag carried alongside each operation (destination register id).

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- resetn  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  operation offered.
- in_ready  out  1  block can accept an operation this cycle.
- in_op  in  3  one-hot operation select: [0] signed low half, [1] signed high half, [2] unsigned high half.
- in_src1  in  WIDTH  multiplicand.
- in_src2  in  WIDTH  multiplier.
- in_tag  in  TAG_W  sideband tag, returned unchanged with the result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result this cycle.
- out_result  out  WIDTH  selected half of the product.
- out_tag  out  TAG_W  tag of the returned operation.
- flush  in  1  discard all in-flight operations. Present only with MUL_FLUSH_EN.

## Operation
- Each operand is extended to WIDTH+1 bits: sign-extended for op[0] and op[1], zero-extended for op[2]. The (2·WIDTH+2)-bit product is computed in stage 0.
- Result field selection:
  - op[0]: product[WIDTH-1:0].
  - op[1] and op[2]: product[2·WIDTH-1:WIDTH].
- Multi-hot op: the result is the bitwise OR of the selected fields.
- op == 0: the result is 0. The operation still flows through the pipe and returns its tag.
- Pipeline structure: STAGES register slices, each holding valid, result/product, op and tag. The remaining stages only delay and back-pressure; synthesis may retime the multiplier across them.
- Stage advance rule: stage k loads from stage k-1 when stage k is empty or is itself advancing. The last stage advances on out_ready.
- in_ready = ~valid[0] | advance[0].
- Ordering is strictly in-order. An accepted operation is never dropped except by flush or reset.
- Transfers occur only on the valid & ready cycle of each side.
- While out_valid is high and out_ready is low, out_result and out_tag hold stable.

## Timing
- Latency: an operation accepted in cycle N presents out_valid in cycle N+STAGES, provided no stall occurs.
- Throughput: one operation per cycle while out_ready stays high.
- Under back-pressure, at most STAGES operations are held. in_ready falls once every stage is full and out_ready is low.
- in_ready is combinational from out_ready through the stage chain.
- Reset values: all stage valids are 0, so out_valid = 0 and in_ready = 1. out_result and out_tag reset to 0.
- Reset mid-operation: in-flight operations are lost. No output pulse occurs after resetn rises.
- Flush (when compiled in), same-cycle rules:
  - All stage valids clear at the clock edge.
  - in_ready is forced low, so no new operation is accepted.
  - An out_valid & out_ready handshake in the flush cycle still completes.
  - out_valid is 0 in the following cycle.

## Configuration
- MUL_FLUSH_EN defined:
  - The flush port exists and behaves as described under Timing.
- MUL_FLUSH_EN undefined:
  - No flush port; operations can only be removed by reset.
  - All other behaviour is identical.

## Structure
- The shared package mul_pkg holds:
  - the op bit indices (MUL_OP_LO = 0, MUL_OP_HI = 1, MUL_OP_HIU = 2);
  - the op vector width constant (3);
  - a packed stage-payload struct typedef (result, tag).
- One sub-module, mul_pipe_slice: a single valid/ready register slice with flush and async reset. It is instantiated STAGES-1 times after the arithmetic stage.

## Test plan
- WIDTH=32, STAGES=2, src1=src2=0xFFFFFFFF:
  - op[0] → 0x00000001;
  - op[1] → 0x00000000;
  - op[2] → 0xFFFFFFFE;
  - each out_valid appears exactly 2 cycles after accept.
- src1=src2=0x80000000 → op[0] 0x00000000, op[1] 0x40000000, op[2] 0x40000000. Repeat at WIDTH=16 with 0x8000 → op[1] 0x4000.
- Back-to-back issue with tags 1,2,3,4 and out_ready low for 5 cycles → in_ready low after 2 accepts. Results return in tag order with no loss or duplication.
- Flush (MUL_FLUSH_EN) one cycle after accepting tags 7 and 8 → neither tag appears. in_ready is 0 in the flush cycle and 1 in the next.
- resetn pulled low with 2 ops in flight → out_valid is 0 immediately and stays 0 after release. The next accepted op returns with its correct result.
- op=0b000 with tag 9 → out_result 0 and out_tag 9 at the normal latency.
